// File: rtl/fib_table_seq.sv
// Fibonacci table with LOOKUP and FLOOR request service.
// After reset the table F(0..DEPTH-1) is filled one entry per cycle, with
// overflow detection at WIDTH+1 bits. Requests are then served one at a time:
//   LOOKUP returns F(idx) one cycle after accept.
//   FLOOR returns the largest k with F(k) <= val, found by a downward scan
//   from max_idx.
// Handshakes: a request transfers on a clock edge where req_valid & req_ready.
// A response is presented with rsp_valid and held stable until an edge where
// rsp_valid & rsp_ready. Only one request is outstanding at any time.
module fib_table_seq #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 33,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [WIDTH-1:0] req_val,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [IDX_W-1:0] rsp_idx,
  output logic             rsp_err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_LOOK = 3'd2,
    S_SRCH = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Address width of the table storage; IDX_W is at least this wide.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH at IDX_W+1 bits so the fill counter can reach it even when DEPTH = 2**IDX_W.
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CNT_TWO = (IDX_W+1)'(2);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t r_state;
  state_t w_next_state;

  // Table storage (not reset; always fully rewritten after reset).
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  // Fill datapath
  logic [IDX_W:0]   r_fill_cnt;
  logic [WIDTH-1:0] r_fib_a;     // F(c-2)
  logic [WIDTH-1:0] r_fib_b;     // F(c-1)
  logic             r_ovf;       // a carry-out has been seen; later entries are invalid
  logic [IDX_W-1:0] r_max_idx;   // last representable index
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_fill_val;
  logic             w_fill_we;
  logic             w_carry;
  logic             w_fill_done;

  // Request / search datapath
  logic [IDX_W-1:0] r_req_idx;
  logic [WIDTH-1:0] r_req_val;
  logic [IDX_W-1:0] r_k;         // next table index to read during the scan
  logic [WIDTH-1:0] r_rd_data;   // F(r_rd_k), registered read
  logic [IDX_W-1:0] r_rd_k;
  logic             r_rd_vld;
  logic             w_accept;
  logic             w_hit;
  logic             w_look_ok;
  logic [AW-1:0]    w_look_addr;
  logic [AW-1:0]    w_srch_addr;
  logic [AW-1:0]    w_fill_addr;
  logic [WIDTH-1:0] w_look_rd;

  // Response registers
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [IDX_W-1:0] r_rsp_idx;
  logic             r_rsp_err;

  assign w_sum       = {1'b0, r_fib_a} + {1'b0, r_fib_b};
  assign w_fill_we   = (r_state == S_INIT) && (r_fill_cnt < DEPTH_X);
  assign w_fill_done = (r_fill_cnt == DEPTH_X);
  assign w_carry     = (r_fill_cnt >= CNT_TWO) && w_sum[WIDTH];
  assign w_fill_addr = r_fill_cnt[AW-1:0];

  assign w_look_addr = r_req_idx[AW-1:0];
  assign w_srch_addr = r_k[AW-1:0];
  assign w_look_ok   = ({1'b0, r_req_idx} < DEPTH_X) && (r_req_idx <= r_max_idx);
  assign w_look_rd   = w_look_ok ? r_mem[w_look_addr] : '0;
  // F(0) = 0 satisfies any val, so the scan always terminates by k = 0.
  assign w_hit       = r_rd_vld && (r_rd_data <= r_req_val);

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_idx   = r_rsp_idx;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

  // Value written into the table entry selected by the fill counter.
  always_comb begin
    w_fill_val = w_sum[WIDTH-1:0];
    if (r_fill_cnt == '0) begin
      w_fill_val = '0;
    end else if (r_fill_cnt == CNT_ONE) begin
      w_fill_val = WIDTH'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    init_done    = 1'b1;
    req_ready    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_INIT: begin
        init_done = 1'b0;
        if (w_fill_done) begin
          w_next_state = S_IDLE;
        end
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_next_state = req_op ? S_SRCH : S_LOOK;
        end
      end
      S_LOOK: begin
        w_next_state = S_RESP;
      end
      S_SRCH: begin
        if (w_hit) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        init_done    = 1'b0;
        w_next_state = S_INIT;
      end
    endcase
  end

  // Table write port, active only while filling.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_mem[w_fill_addr] <= w_fill_val;
    end
  end

  // Fill sequencing: running Fibonacci pair, overflow flag and max_idx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_cnt <= '0;
      r_fib_a    <= '0;
      r_fib_b    <= '0;
      r_ovf      <= 1'b0;
      r_max_idx  <= '0;
    end else if (w_fill_we) begin
      r_fill_cnt <= r_fill_cnt + CNT_ONE;
      r_fib_a    <= r_fib_b;
      r_fib_b    <= w_fill_val;
      if (w_carry) begin
        r_ovf <= 1'b1;
      end else if (!r_ovf) begin
        r_max_idx <= r_fill_cnt[IDX_W-1:0];
      end
    end
  end

  // Request capture and the pipelined downward scan (read k, compare k+1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_idx <= '0;
      r_req_val <= '0;
      r_k       <= '0;
      r_rd_data <= '0;
      r_rd_k    <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req_idx <= req_idx;
        r_req_val <= req_val;
        r_k       <= r_max_idx;
        r_rd_vld  <= 1'b0;
      end else if (r_state == S_SRCH) begin
        r_rd_data <= r_mem[w_srch_addr];
        r_rd_k    <= r_k;
        r_rd_vld  <= 1'b1;
        if (r_k != '0) begin
          r_k <= r_k - IDX_ONE;
        end
      end
    end
  end

  // Response registers: load on LOOK or scan hit, clear valid on consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_idx   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_LOOK: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_look_rd;
          r_rsp_idx   <= r_req_idx;
          r_rsp_err   <= !w_look_ok;
        end
        S_SRCH: begin
          if (w_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rd_data;
            r_rsp_idx   <= r_rd_k;
            r_rsp_err   <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_table_seq.sv
// Bench for fib_table_seq: a default instance (WIDTH=23, DEPTH=33) and a
// small instance (WIDTH=8, DEPTH=16) share one set of request drivers,
// steered by sel. Expected values come from constants and a plain
// arithmetic Fibonacci model.
module tb_fib_table_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Common drivers
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [5:0]  req_idx = '0;
  logic [22:0] req_val = '0;
  logic        rsp_ready = 1'b0;

  // Default instance
  logic        d_init_done, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [22:0] d_rsp_data;
  logic [5:0]  d_rsp_idx;
  logic [2:0]  d_dbg_state;
  // Small instance
  logic        s_init_done, s_req_ready, s_rsp_valid, s_rsp_err;
  logic [7:0]  s_rsp_data;
  logic [5:0]  s_rsp_idx;
  logic [2:0]  s_dbg_state;

  logic d_req_valid, s_req_valid, d_rsp_ready, s_rsp_ready;
  assign d_req_valid = req_valid & ~sel;
  assign s_req_valid = req_valid & sel;
  assign d_rsp_ready = rsp_ready & ~sel;
  assign s_rsp_ready = rsp_ready & sel;

  // Selected-instance view of the outputs
  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [22:0] m_rsp_data;
  logic [5:0]  m_rsp_idx;
  assign m_req_ready = sel ? s_req_ready : d_req_ready;
  assign m_rsp_valid = sel ? s_rsp_valid : d_rsp_valid;
  assign m_rsp_err   = sel ? s_rsp_err   : d_rsp_err;
  assign m_rsp_data  = sel ? {15'b0, s_rsp_data} : d_rsp_data;
  assign m_rsp_idx   = sel ? s_rsp_idx   : d_rsp_idx;

  fib_table_seq u_dut (
    .clk(clk), .rst(rst), .init_done(d_init_done),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_op(req_op),
    .req_idx(req_idx), .req_val(req_val),
    .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_data(d_rsp_data),
    .rsp_idx(d_rsp_idx), .rsp_err(d_rsp_err), .dbg_state(d_dbg_state)
  );

  fib_table_seq #(.WIDTH(8), .DEPTH(16), .IDX_W(6)) u_small (
    .clk(clk), .rst(rst), .init_done(s_init_done),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(req_op),
    .req_idx(req_idx), .req_val(req_val[7:0]),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .rsp_idx(s_rsp_idx), .rsp_err(s_rsp_err), .dbg_state(s_dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint fib(input int n);
    longint a = 0;
    longint b = 1;
    longint t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int model_max(input int width, input int depth);
    int n = 0;
    while ((n + 1 < depth) && (fib(n + 1) < (longint'(1) << width))) n++;
    return n;
  endfunction

  task automatic model_req(input int width, input int depth, input logic op,
                           input int idx, input longint val,
                           output longint ed, output int ei, output int ee, output int el);
    int mx = model_max(width, depth);
    int k;
    if (!op) begin
      ei = idx;
      el = 1;
      if (idx > mx) begin ee = 1; ed = 0; end
      else begin ee = 0; ed = fib(idx); end
    end else begin
      k = mx;
      while (fib(k) > val) k--;
      ed = fib(k); ei = k; ee = 0; el = (mx - k) + 2;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1 right after reset release; returns init_done rise cycles.
  task automatic wait_init(output int d_first, output int s_first);
    int cyc = 0;
    d_first = 0;
    s_first = 0;
    while ((!d_init_done || !s_init_done) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (d_init_done && d_first == 0) d_first = cyc;
      if (s_init_done && s_first == 0) s_first = cyc;
    end
  endtask

  // Issue one request on the selected instance and consume its response.
  task automatic do_req(input logic op, input logic [5:0] idx, input logic [22:0] val,
                        output longint data, output int ridx, output int err, output int lat);
    int cnt = 0;
    data = 0; ridx = 0; err = 0; lat = 0;
    while (!m_req_ready && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    if (!m_req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_ready_timeout: got 0, expected 1");
      return;
    end
    req_valid = 1'b1; req_op = op; req_idx = idx; req_val = val;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!m_rsp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!m_rsp_valid) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_valid_timeout: got 0, expected 1");
      return;
    end
    data = m_rsp_data; ridx = m_rsp_idx; err = m_rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic        op;
    logic [5:0]  idx;
    logic [22:0] val;
    longint      ed;
    int          ei;
    int          ee;
    int          el;
  } vec_t;

  vec_t vt[16];

  initial begin
    int d_first, s_first;
    longint data, ed;
    int ridx, err, lat, ei, ee, el, w, dp;

    vt[0]  = '{1'b0, 1'b0, 6'd32, 23'd0,       2178309, 32, 0, 1};
    vt[1]  = '{1'b0, 1'b0, 6'd0,  23'd0,       0,       0,  0, 1};
    vt[2]  = '{1'b0, 1'b0, 6'd40, 23'd0,       0,       40, 1, 1};
    vt[3]  = '{1'b0, 1'b0, 6'd33, 23'd0,       0,       33, 1, 1};
    vt[4]  = '{1'b0, 1'b0, 6'd1,  23'd0,       1,       1,  0, 1};
    vt[5]  = '{1'b0, 1'b1, 6'd0,  23'd100,     89,      11, 0, 23};
    vt[6]  = '{1'b0, 1'b1, 6'd0,  23'd0,       0,       0,  0, 34};
    vt[7]  = '{1'b0, 1'b1, 6'd0,  23'd1,       1,       2,  0, 32};
    vt[8]  = '{1'b0, 1'b1, 6'd0,  23'd2178309, 2178309, 32, 0, 2};
    vt[9]  = '{1'b0, 1'b1, 6'd0,  23'd8388607, 2178309, 32, 0, 2};
    vt[10] = '{1'b0, 1'b1, 6'd0,  23'd2178308, 1346269, 31, 0, 3};
    vt[11] = '{1'b1, 1'b0, 6'd13, 23'd0,       233,     13, 0, 1};
    vt[12] = '{1'b1, 1'b0, 6'd14, 23'd0,       0,       14, 1, 1};
    vt[13] = '{1'b1, 1'b0, 6'd15, 23'd0,       0,       15, 1, 1};
    vt[14] = '{1'b1, 1'b1, 6'd0,  23'd255,     233,     13, 0, 2};
    vt[15] = '{1'b1, 1'b1, 6'd0,  23'd232,     144,     12, 0, 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", d_init_done, 0);
    check("rst_req_ready", d_req_ready, 0);
    check("rst_rsp_valid", d_rsp_valid, 0);
    check("rst_rsp_data", d_rsp_data, 0);
    check("rst_rsp_err", d_rsp_err, 0);
    check("rst_small_init_done", s_init_done, 0);

    // Release and measure the fill time
    rst = 1'b1;
    wait_init(d_first, s_first);
    check("init_cycles", d_first, 34);
    check("init_cycles_small", s_first, 17);
    check("init_req_ready", d_req_ready, 1);
    check("init_rsp_err", d_rsp_err, 0);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      sel = vt[i].sel;
      do_req(vt[i].op, vt[i].idx, vt[i].val, data, ridx, err, lat);
      check($sformatf("vec%0d_data", i), data, vt[i].ed);
      check($sformatf("vec%0d_idx", i), ridx, vt[i].ei);
      check($sformatf("vec%0d_err", i), err, vt[i].ee);
      check($sformatf("vec%0d_lat", i), lat, vt[i].el);
    end

    // Back-pressure: response held with rsp_ready low and req_valid high
    sel = 1'b0;
    req_valid = 1'b1; req_op = 1'b0; req_idx = 6'd10;
    @(posedge clk); #1;
    req_idx = 6'd5;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      check("hold_rsp_valid", d_rsp_valid, 1);
      check("hold_rsp_data", d_rsp_data, 55);
      check("hold_rsp_idx", d_rsp_idx, 10);
      check("hold_req_ready", d_req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("consume_rsp_valid", d_rsp_valid, 0);
    check("consume_req_ready", d_req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("second_accept_ready_low", d_req_ready, 0);
    @(posedge clk); #1;
    check("second_rsp_valid", d_rsp_valid, 1);
    check("second_rsp_data", d_rsp_data, 5);
    check("second_rsp_idx", d_rsp_idx, 5);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Randomized requests against the model
    for (int i = 0; i < 150; i++) begin
      sel = 1'($urandom_range(0, 1));
      w  = sel ? 8 : 23;
      dp = sel ? 16 : 33;
      req_op = 1'($urandom_range(0, 1));
      req_idx = 6'($urandom_range(0, 63));
      if (sel) req_val = 23'($urandom_range(0, 255));
      else if ($urandom_range(0, 1) == 1) req_val = 23'($urandom_range(0, 200));
      else req_val = 23'($urandom_range(0, 8388607));
      model_req(w, dp, req_op, int'(req_idx), longint'(req_val), ed, ei, ee, el);
      do_req(req_op, req_idx, req_val, data, ridx, err, lat);
      check($sformatf("rnd%0d_data", i), data, ed);
      check($sformatf("rnd%0d_idx", i), ridx, ei);
      check($sformatf("rnd%0d_err", i), err, ee);
      check($sformatf("rnd%0d_lat", i), lat, el);
    end

    // Reset during a FLOOR scan
    sel = 1'b0;
    do_req(1'b0, 6'd20, 23'd0, data, ridx, err, lat);
    check("pre_reset_lookup", data, 6765);
    req_valid = 1'b1; req_op = 1'b1; req_val = 23'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_srch_rsp_valid", d_rsp_valid, 0);
    rst = 1'b0;
    #1;
    check("abort_init_done", d_init_done, 0);
    check("abort_req_ready", d_req_ready, 0);
    check("abort_rsp_valid", d_rsp_valid, 0);
    check("abort_rsp_data", d_rsp_data, 0);
    check("abort_rsp_idx", d_rsp_idx, 0);
    check("abort_rsp_err", d_rsp_err, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    wait_init(d_first, s_first);
    check("refill_cycles", d_first, 34);
    check("refill_cycles_small", s_first, 17);
    do_req(1'b1, 6'd0, 23'd100, data, ridx, err, lat);
    check("post_reset_floor_data", data, 89);
    check("post_reset_floor_idx", ridx, 11);
    check("post_reset_floor_lat", lat, 23);
    sel = 1'b1;
    do_req(1'b1, 6'd0, 23'd200, data, ridx, err, lat);
    check("post_reset_small_data", data, 144);
    check("post_reset_small_idx", ridx, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
